// File: rtl/tick_interval_timer.sv
// Programmable interval timer clocked by qualified time-base ticks.
// Supports one-shot and auto-reload modes, with an expiry strobe and a square-wave output.
module tick_interval_timer #(
   parameter int CNT_W         = 16,
   parameter bit TICK_IS_LEVEL = 1'b1
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             tick,
   input  logic             start,
   input  logic             stop,
   input  logic             periodic,
   input  logic [CNT_W-1:0] load_value,
   output logic             busy,
   output logic [CNT_W-1:0] count,
   output logic             expired,
   output logic             q,
   output logic             err
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   localparam logic [CNT_W-1:0] CNT_ZERO = '0;
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] count_reg, count_next;
   logic [CNT_W-1:0] reload_reg, reload_next;
   logic             mode_reg, mode_next;
   logic             expired_reg, expired_next;
   logic             q_reg, q_next;
   logic             err_reg, err_next;
   logic             tick_en;

   // A level input is reduced to a single-cycle enable on its rising edge.
   generate
      if (TICK_IS_LEVEL) begin : g_level
         logic tick_prev_reg;
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) tick_prev_reg <= 1'b0;
            else          tick_prev_reg <= tick;
         end
         assign tick_en = tick & ~tick_prev_reg;
      end else begin : g_strobe
         assign tick_en = tick;
      end
   endgenerate

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg   <= IDLE;
         count_reg   <= CNT_ZERO;
         reload_reg  <= CNT_ZERO;
         mode_reg    <= 1'b0;
         expired_reg <= 1'b0;
         q_reg       <= 1'b0;
         err_reg     <= 1'b0;
      end else begin
         state_reg   <= state_next;
         count_reg   <= count_next;
         reload_reg  <= reload_next;
         mode_reg    <= mode_next;
         expired_reg <= expired_next;
         q_reg       <= q_next;
         err_reg     <= err_next;
      end
   end

   // Requests are mutually exclusive per cycle: stop, then start, then tick.
   always_comb begin
      state_next   = state_reg;
      count_next   = count_reg;
      reload_next  = reload_reg;
      mode_next    = mode_reg;
      expired_next = 1'b0;
      q_next       = q_reg;
      err_next     = 1'b0;

      if (stop) begin
         state_next = IDLE;
         count_next = CNT_ZERO;
      end else if (start) begin
         if (load_value == CNT_ZERO) begin
            err_next = 1'b1;
         end else begin
            state_next  = RUN;
            count_next  = load_value;
            reload_next = load_value;
            mode_next   = periodic;
         end
      end else if (tick_en && (state_reg == RUN)) begin
         if (count_reg == CNT_ONE) begin
            expired_next = 1'b1;
            q_next       = ~q_reg;
            if (mode_reg) begin
               count_next = reload_reg;
            end else begin
               count_next = CNT_ZERO;
               state_next = IDLE;
            end
         end else if (count_reg > CNT_ONE) begin
            count_next = count_reg - CNT_ONE;
         end
      end
   end

   assign busy    = (state_reg == RUN);
   assign count   = count_reg;
   assign expired = expired_reg;
   assign q       = q_reg;
   assign err     = err_reg;

endmodule

// File: tb/tb_tick_interval_timer.sv
// Directed bench: strobe-tick instance driven from a vector table, level-tick
// instance and asynchronous reset exercised by hand-written sequences.
module tb_tick_interval_timer;

   typedef struct packed {
      logic        start;
      logic        stop;
      logic        periodic;
      logic        tick;
      logic [15:0] lv;
      logic        busy;
      logic [15:0] cnt;
      logic        expired;
      logic        q;
      logic        err;
   } vec_t;

   logic        clk;
   logic        reset_n;
   logic        stop;
   logic        periodic;
   logic [15:0] load_value;
   logic        start0, tick0, start1, tick1;
   logic        busy0, expired0, q0, err0;
   logic        busy1, expired1, q1, err1;
   logic [15:0] count0, count1;

   int tests_run = 0;
   int tests_failed = 0;
   vec_t vecs[$];

   tick_interval_timer #(.CNT_W(16), .TICK_IS_LEVEL(1'b0)) dut0 (
      .clk(clk), .reset_n(reset_n), .tick(tick0), .start(start0), .stop(stop),
      .periodic(periodic), .load_value(load_value), .busy(busy0), .count(count0),
      .expired(expired0), .q(q0), .err(err0)
   );

   tick_interval_timer #(.CNT_W(16), .TICK_IS_LEVEL(1'b1)) dut1 (
      .clk(clk), .reset_n(reset_n), .tick(tick1), .start(start1), .stop(stop),
      .periodic(periodic), .load_value(load_value), .busy(busy1), .count(count1),
      .expired(expired1), .q(q1), .err(err1)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic add(input logic st, input logic sp, input logic per, input logic tk,
                      input logic [15:0] lv, input logic b, input logic [15:0] c,
                      input logic e, input logic qq, input logic er);
      vec_t v;
      v.start = st; v.stop = sp; v.periodic = per; v.tick = tk; v.lv = lv;
      v.busy = b; v.cnt = c; v.expired = e; v.q = qq; v.err = er;
      vecs.push_back(v);
   endtask

   task automatic idle0(input int n, input logic b, input logic [15:0] c, input logic qq);
      for (int k = 0; k < n; k++) add(0, 0, 0, 0, 16'd0, b, c, 0, qq, 0);
   endtask

   task automatic check_dut0(input string tag, input logic b, input logic [15:0] c,
                             input logic e, input logic qq, input logic er);
      check({tag, ".busy"}, {31'd0, busy0}, {31'd0, b});
      check({tag, ".count"}, {16'd0, count0}, {16'd0, c});
      check({tag, ".expired"}, {31'd0, expired0}, {31'd0, e});
      check({tag, ".q"}, {31'd0, q0}, {31'd0, qq});
      check({tag, ".err"}, {31'd0, err0}, {31'd0, er});
   endtask

   initial begin
      // One-shot N=3, ticks every 4 clocks
      add(1, 0, 0, 0, 16'd3, 1, 16'd3, 0, 0, 0);
      idle0(3, 1, 16'd3, 0);
      add(0, 0, 0, 1, 16'd0, 1, 16'd2, 0, 0, 0);
      idle0(3, 1, 16'd2, 0);
      add(0, 0, 0, 1, 16'd0, 1, 16'd1, 0, 0, 0);
      idle0(3, 1, 16'd1, 0);
      add(0, 0, 0, 1, 16'd0, 0, 16'd0, 1, 1, 0);
      idle0(1, 0, 16'd0, 1);
      // Periodic N=2, six back-to-back ticks
      add(1, 0, 1, 0, 16'd2, 1, 16'd2, 0, 1, 0);
      add(0, 0, 0, 1, 16'd0, 1, 16'd1, 0, 1, 0);
      add(0, 0, 0, 1, 16'd0, 1, 16'd2, 1, 0, 0);
      add(0, 0, 0, 1, 16'd0, 1, 16'd1, 0, 0, 0);
      add(0, 0, 0, 1, 16'd0, 1, 16'd2, 1, 1, 0);
      add(0, 0, 0, 1, 16'd0, 1, 16'd1, 0, 1, 0);
      add(0, 0, 0, 1, 16'd0, 1, 16'd2, 1, 0, 0);
      idle0(1, 1, 16'd2, 0);
      // Retrigger to 5, then zero-length starts rejected while running
      add(1, 0, 0, 0, 16'd5, 1, 16'd5, 0, 0, 0);
      add(1, 0, 0, 0, 16'd0, 1, 16'd5, 0, 0, 1);
      add(1, 0, 0, 1, 16'd0, 1, 16'd5, 0, 0, 1);
      idle0(1, 1, 16'd5, 0);
      add(0, 0, 0, 1, 16'd0, 1, 16'd4, 0, 0, 0);
      add(0, 0, 0, 1, 16'd0, 1, 16'd3, 0, 0, 0);
      add(0, 0, 0, 1, 16'd0, 1, 16'd2, 0, 0, 0);
      add(0, 0, 0, 1, 16'd0, 1, 16'd1, 0, 0, 0);
      // stop+start+tick at count=1: stop wins, no expiry
      add(1, 1, 0, 1, 16'd7, 0, 16'd0, 0, 0, 0);
      add(0, 0, 0, 1, 16'd0, 0, 16'd0, 0, 0, 0);
      add(1, 0, 0, 0, 16'd1, 1, 16'd1, 0, 0, 0);
      add(1, 0, 0, 1, 16'd6, 1, 16'd6, 0, 0, 0);
      add(0, 0, 0, 1, 16'd0, 1, 16'd5, 0, 0, 0);
      add(0, 1, 0, 0, 16'd0, 0, 16'd0, 0, 0, 0);
      // Reject in IDLE
      add(1, 0, 0, 0, 16'd0, 0, 16'd0, 0, 0, 1);
      idle0(1, 0, 16'd0, 0);
      // Periodic N=1 expires on every tick
      add(1, 0, 1, 0, 16'd1, 1, 16'd1, 0, 0, 0);
      add(0, 0, 0, 1, 16'd0, 1, 16'd1, 1, 1, 0);
      add(0, 0, 0, 1, 16'd0, 1, 16'd1, 1, 0, 0);
      idle0(1, 1, 16'd1, 0);
      add(0, 1, 0, 0, 16'd0, 0, 16'd0, 0, 0, 0);
      // Maximum interval
      add(1, 0, 0, 0, 16'hFFFF, 1, 16'hFFFF, 0, 0, 0);
      add(0, 0, 0, 1, 16'd0, 1, 16'hFFFE, 0, 0, 0);
      add(0, 1, 0, 0, 16'd0, 0, 16'd0, 0, 0, 0);

      reset_n = 1'b0; stop = 0; periodic = 0; load_value = '0;
      start0 = 0; tick0 = 0; start1 = 0; tick1 = 0;
      repeat (2) cycle();
      check_dut0("reset0", 0, 16'd0, 0, 0, 0);
      check("reset1.busy", {31'd0, busy1}, 32'd0);
      check("reset1.count", {16'd0, count1}, 32'd0);
      #2 reset_n = 1'b1;
      cycle();

      for (int i = 0; i < vecs.size(); i++) begin
         start0 = vecs[i].start; stop = vecs[i].stop; periodic = vecs[i].periodic;
         tick0 = vecs[i].tick; load_value = vecs[i].lv;
         cycle();
         start0 = 0; stop = 0; tick0 = 0; periodic = 0; load_value = '0;
         $display("[TB] vec %0d: busy=%0b count=%0h expired=%0b q=%0b err=%0b",
                  i, busy0, count0, expired0, q0, err0);
         check_dut0($sformatf("vec%0d", i), vecs[i].busy, vecs[i].cnt,
                    vecs[i].expired, vecs[i].q, vecs[i].err);
      end

      // Level tick: square wave period 8, N=4, one count per rising edge
      start1 = 1; load_value = 16'd4; periodic = 0;
      cycle();
      start1 = 0; load_value = '0;
      check("lvl.load", {16'd0, count1}, 32'd4);
      for (int p = 0; p < 4; p++) begin
         tick1 = 1;
         cycle();
         $display("[TB] level edge %0d: count=%0h expired=%0b busy=%0b q=%0b",
                  p, count1, expired1, busy1, q1);
         check($sformatf("lvl.edge%0d.count", p), {16'd0, count1}, 32'(3 - p));
         check($sformatf("lvl.edge%0d.expired", p), {31'd0, expired1}, (p == 3) ? 32'd1 : 32'd0);
         check($sformatf("lvl.edge%0d.busy", p), {31'd0, busy1}, (p == 3) ? 32'd0 : 32'd1);
         check($sformatf("lvl.edge%0d.q", p), {31'd0, q1}, (p == 3) ? 32'd1 : 32'd0);
         repeat (3) cycle();
         check($sformatf("lvl.hold%0d.count", p), {16'd0, count1}, 32'(3 - p));
         check($sformatf("lvl.hold%0d.expired", p), {31'd0, expired1}, 32'd0);
         tick1 = 0;
         repeat (4) cycle();
      end

      // Async reset mid-RUN, asserted and released between edges
      start0 = 1; load_value = 16'd5; periodic = 1;
      cycle();
      start0 = 0; load_value = '0; periodic = 0;
      tick0 = 1;
      repeat (2) cycle();
      tick0 = 0;
      check_dut0("prerst", 1, 16'd3, 0, 0, 0);
      #2 reset_n = 1'b0;
      #1;
      $display("[TB] async reset: busy=%0b count=%0h q=%0b", busy0, count0, q0);
      check_dut0("asyncrst", 0, 16'd0, 0, 0, 0);
      #2 reset_n = 1'b1;
      tick0 = 1;
      repeat (3) cycle();
      tick0 = 0;
      check_dut0("postrst", 0, 16'd0, 0, 0, 0);
      start0 = 1; load_value = 16'd2;
      cycle();
      start0 = 0; load_value = '0;
      check_dut0("restart", 1, 16'd2, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
